// File: rtl/master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : master_pkg
//  Description : Master state encodings and maze status codes shared with
//                the maze state machine.
//  Revision    : 1.0 - initial release
// ============================================================================
package master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MAZE = 2'b01,
        WIN  = 2'b10,
        LOSE = 2'b11
    } master_state_e;

    localparam logic [3:0] GOAL = 4'hA;
    localparam logic [3:0] FAIL = 4'hB;

endpackage
`default_nettype wire

// File: rtl/master_sm_btn_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_edge
//  Description : Two-flop synchronizer with rising-edge pulse for a raw button.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic filled_q, filled_d;
    logic armed_q, armed_d;

    // A button held through reset must be seen low once before it can fire,
    // so the edge detector only arms on a genuine post-reset low sample.
    always_comb begin
        sync1_d  = btn_in;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        filled_d = 1'b1;
        armed_d  = armed_q | (filled_q & ~sync1_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            filled_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            filled_q <= filled_d;
            armed_q  <= armed_d;
        end
    end

    assign pulse = sync2_q & ~prev_q & armed_q;

endmodule
`default_nettype wire

// File: rtl/master_sm.sv
`default_nettype none
// ============================================================================
//  Module      : master_sm
//  Description : Master game controller: start/acknowledge, maze time budget
//                with one-second prescaler, win/lose outcome and win counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module master_sm
    import master_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int TIME_LIMIT_S = 30
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTNC,
    input  logic [3:0] MazeSM_OUT,
    output logic [1:0] MASTER_STATE,
    output logic [7:0] TIME_LEFT,
    output logic [3:0] WIN_COUNT
);

    localparam int               PRESC_W   = $clog2(CLK_FREQ_HZ);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);
    localparam logic [7:0]       TIME_INIT = 8'(TIME_LIMIT_S);

    master_state_e        state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [7:0]           time_left_q, time_left_d;
    logic [3:0]           win_count_q, win_count_d;
    logic                 start;

    btn_edge u_btn_edge (
        .clk    (CLK),
        .rst    (RESET),
        .btn_in (BTNC),
        .pulse  (start)
    );

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        time_left_d = time_left_q;
        win_count_d = win_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = MAZE;
                    time_left_d = TIME_INIT;
                    presc_d     = '0;
                end
            end
            MAZE: begin
                // Goal beats fail beats timeout; the clock freezes on any exit.
                if (MazeSM_OUT == GOAL) begin
                    state_d = WIN;
                    if (win_count_q != 4'hF) begin
                        win_count_d = win_count_q + 4'd1;
                    end
                end else if (MazeSM_OUT == FAIL) begin
                    state_d = LOSE;
                end else if (time_left_q == 8'd0) begin
                    state_d = LOSE;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d     = '0;
                    time_left_d = time_left_q - 8'd1;
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            WIN, LOSE: begin
                if (start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            time_left_q <= 8'd0;
            win_count_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            time_left_q <= time_left_d;
            win_count_q <= win_count_d;
        end
    end

    assign MASTER_STATE = state_q;
    assign TIME_LEFT    = time_left_q;
    assign WIN_COUNT    = win_count_q;

endmodule
`default_nettype wire
